reg_write_arbiter: RTL
======================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter WORD_WIDTH, default 32, data word width (same value as `WORD_WIDTH).
REQ-002 Parameter REG_NUM_LOG, default 5, register address width (same value as `REG_NUM_LOG); REG_NUM = 2**REG_NUM_LOG.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock, shared with RegFile.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req0Valid / req1Valid  input  1  write-back request from requester 0 (ALU) / 1 (load unit).
REQ-007 req0Addr / req1Addr  input  REG_NUM_LOG  destination register.
REQ-008 req0Value / req1Value  input  WORD_WIDTH  write data.
REQ-009 req0Ready / req1Ready  output  1  grant; transfer occurs when Valid and Ready are both high at a rising edge.
REQ-010 writeEnable  output  1  RegFile write strobe, registered.
REQ-011 writeAddr  output  REG_NUM_LOG  RegFile write address, registered.
REQ-012 writeValue  output  WORD_WIDTH  RegFile write data, registered.
REQ-013 issueValid  input  1  decode marks a destination register as pending.
REQ-014 issueAddr  input  REG_NUM_LOG  register being marked pending.
REQ-015 busyMask  output  REG_NUM  per-register pending-write bits, registered.

Function
REQ-016 Grant SHALL be combinational from the Valid inputs and the priority pointer; at most one of req0Ready/req1Ready is high per cycle.
REQ-017 Single valid requester SHALL be granted regardless of pointer; no valid requester -> both Ready low.
REQ-018 Priority pointer is a 2-state FSM: PRI0 (req0 wins ties), PRI1 (req1 wins ties); accepted transfer from requester N moves state to the other requester's priority; no transfer -> state holds.
REQ-019 Accepted request SHALL appear on writeAddr/writeValue with writeEnable=1 exactly one cycle later (latency 1); cycle with no transfer -> writeEnable=0 next cycle, writeAddr/writeValue hold previous values.
REQ-020 Accepted request with Addr=0 SHALL be consumed (Ready high) but SHALL NOT assert writeEnable; pointer still advances.
REQ-021 Requester holding Valid without Ready SHALL keep Addr/Value stable; block SHALL not drop or reorder a requester's own transfers.
REQ-022 Worst-case wait for a continuously valid requester: one cycle.
REQ-023 issueValid at an edge SHALL set busyMask[issueAddr] at that edge; issueAddr=0 ignored; busyMask[0] is constant 0.
REQ-024 A registered write (writeEnable=1 in a cycle) SHALL clear busyMask[writeAddr] at the following edge.
REQ-025 Set and clear of the same bit at the same edge: set wins (newer producer pending).
REQ-026 Set of an already-busy bit: bit stays 1, no counting.

Reset
REQ-027 rst_n low SHALL immediately force writeEnable=0, writeAddr=0, writeValue=0, busyMask=0, pointer=PRI0, independent of clk.
REQ-028 During reset req0Ready/req1Ready SHALL be 0; a request in flight at reset assertion is discarded, not written.
REQ-029 First grant possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 WORD_WIDTH, REG_NUM_LOG, ENABLE/DISABLE constants and pointer-state encodings SHALL live in the shared defines header used by RegFile.
REQ-031 One sub-module, reg_scoreboard (busyMask set/clear logic), is natural; arbiter, FSM and output register stay in the top.

Verification
REQ-032 Only req0: Addr=3, Value=37 -> next cycle writeEnable=1, writeAddr=3, writeValue=37; busyMask[3] cleared the edge after.
REQ-033 Both valid continuously (req0 Addr=2/15, req1 Addr=4/99) from PRI0 -> grants alternate 0,1,0,1; writes 2,4,2,4.
REQ-034 req1 Addr=0, Value=55 -> req1Ready=1, writeEnable stays 0, pointer moves to PRI0.
REQ-035 issueValid Addr=5 same edge as a registered write to 5 -> busyMask[5]=1 after; later write to 5 -> 0.
REQ-036 rst_n pulsed low mid-transfer (req0 Addr=7 accepted the prior edge) -> writeEnable=0 immediately, busyMask=0, no write to 7 after release.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared register-file definitions: word/address widths, strobe levels and the
// write-back priority pointer encoding.
package reg_write_arbiter_pkg;

  localparam int DEF_WORD_WIDTH  = 32;
  localparam int DEF_REG_NUM_LOG = 5;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write tracker: one bit per register, set when decode issues a
// producer, cleared when the register file is written. Register 0 never pends.
module reg_scoreboard
  import reg_write_arbiter_pkg::*;
#(
  parameter int REG_NUM_LOG = DEF_REG_NUM_LOG
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_set_valid,
  input  logic [REG_NUM_LOG-1:0]    i_set_addr,
  input  logic                      i_clr_valid,
  input  logic [REG_NUM_LOG-1:0]    i_clr_addr,
  output logic [2**REG_NUM_LOG-1:0] o_busy
);

  localparam int REG_NUM = 2**REG_NUM_LOG;

  logic [REG_NUM-1:0] r_busy;
  logic [REG_NUM-1:0] w_set;
  logic [REG_NUM-1:0] w_clr;
  logic [REG_NUM-1:0] w_busy_next;

  // Clear first, then set, so a newly issued producer survives a retiring write.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_set_valid) w_set[i_set_addr] = ENABLE;
    if (i_clr_valid) w_clr[i_clr_addr] = ENABLE;
    w_busy_next    = (r_busy & ~w_clr) | w_set;
    w_busy_next[0] = DISABLE;
  end

  // Busy bit storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_next;
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/reg_write_arbiter.sv
// Two-requester write-back arbiter in front of the register file. Round-robin
// on ties, single-cycle registered write port, pending-write busy mask.
//
// state | meaning
// PRI0  | requester 0 (ALU) wins a tie
// PRI1  | requester 1 (load unit) wins a tie
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter int REG_NUM_LOG = DEF_REG_NUM_LOG
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req0Valid,
  input  logic [REG_NUM_LOG-1:0]    req0Addr,
  input  logic [WORD_WIDTH-1:0]     req0Value,
  output logic                      req0Ready,
  input  logic                      req1Valid,
  input  logic [REG_NUM_LOG-1:0]    req1Addr,
  input  logic [WORD_WIDTH-1:0]     req1Value,
  output logic                      req1Ready,
  output logic                      writeEnable,
  output logic [REG_NUM_LOG-1:0]    writeAddr,
  output logic [WORD_WIDTH-1:0]     writeValue,
  input  logic                      issueValid,
  input  logic [REG_NUM_LOG-1:0]    issueAddr,
  output logic [2**REG_NUM_LOG-1:0] busyMask
);

  pri_state_e              r_state;
  pri_state_e              w_state_next;
  logic                    w_grant0;
  logic                    w_grant1;
  logic                    w_wr_en;
  logic [REG_NUM_LOG-1:0]  w_addr;
  logic [WORD_WIDTH-1:0]   w_value;

  logic                    r_write_en;
  logic [REG_NUM_LOG-1:0]  r_write_addr;
  logic [WORD_WIDTH-1:0]   r_write_value;

  // Grant, selected payload and pointer update; the winner hands priority over.
  always_comb begin
    w_grant0     = DISABLE;
    w_grant1     = DISABLE;
    w_state_next = r_state;
    w_addr       = req0Addr;
    w_value      = req0Value;
    if (req0Valid && (!req1Valid || r_state == PRI0)) begin
      w_grant0     = ENABLE;
      w_state_next = PRI1;
    end else if (req1Valid) begin
      w_grant1     = ENABLE;
      w_state_next = PRI0;
      w_addr       = req1Addr;
      w_value      = req1Value;
    end
    // Writes to register 0 are consumed but never reach the register file.
    w_wr_en = (w_grant0 || w_grant1) && (w_addr != '0);
  end

  // Priority pointer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= PRI0;
    else        r_state <= w_state_next;
  end

  // Registered write port; address/data hold when nothing is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write_en    <= DISABLE;
      r_write_addr  <= '0;
      r_write_value <= '0;
    end else begin
      r_write_en <= w_wr_en;
      if (w_wr_en) begin
        r_write_addr  <= w_addr;
        r_write_value <= w_value;
      end
    end
  end

  // Ready is masked by reset so nothing looks accepted while held in reset.
  assign req0Ready   = w_grant0 & rst_n;
  assign req1Ready   = w_grant1 & rst_n;
  assign writeEnable = r_write_en;
  assign writeAddr   = r_write_addr;
  assign writeValue  = r_write_value;

  reg_scoreboard #(
    .REG_NUM_LOG (REG_NUM_LOG)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_set_valid (issueValid),
    .i_set_addr  (issueAddr),
    .i_clr_valid (r_write_en),
    .i_clr_addr  (r_write_addr),
    .o_busy      (busyMask)
  );

endmodule
